// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: N-requester round-robin arbiter with one-hot grant and rotating priority pointer.
// Latency: grant is combinational (zero cycles); one cycle when RR_GNT_REG_EN is defined (registered grant).
// Backpressure: none; arbitration and pointer movement happen only in cycles with i_en high.
//
// Parameters:
//   N    - number of requesters (N >= 2)
//   TYPE - 0: pointer advances by one every enabled cycle
//          1: pointer moves to just past the winner (advances by one when idle)
// Ports:
//   i_clk   - clock, rising edge
//   i_rstn  - asynchronous reset, active HIGH despite the name
//   i_en    - arbitration enable
//   i_req   - request vector, bit i = requester i
//   o_gnt   - grant vector, one-hot or zero
// Optional build macro: RR_GNT_REG_EN registers o_gnt.
module round_robin_arbiter #(
  parameter int N    = 8,
  parameter int TYPE = 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int M = $clog2(N);

  // N always fits in M+1 bits, which is what the modulo-N wrap needs.
  localparam logic [M:0]   N_W  = (M+1)'(N);
  localparam logic [M-1:0] PMAX = M'(N-1);
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  generate
    if (TYPE != 0 && TYPE != 1) begin : g_bad_type
      $error("round_robin_arbiter: TYPE must be 0 or 1");
    end
  endgenerate

  logic [M-1:0] ptr;
  logic [M-1:0] ptr_nxt;
  logic [N-1:0] req_rot;
  logic [M-1:0] pos;
  logic         found;
  logic [M:0]   win_sum;
  logic [M-1:0] win;
  logic [M-1:0] win_inc;
  logic [M-1:0] ptr_inc;
  logic [N-1:0] gnt_c;

  // Rotate requests so bit 0 is the requester at ptr; the first set bit
  // from the bottom is then the first hit in the circular search order.
  assign req_rot = N'({i_req, i_req} >> ptr);

  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pos   = M'(k);
      end
    end
  end

  // Undo the rotation: winner = (ptr + pos) mod N.
  assign win_sum = {1'b0, ptr} + {1'b0, pos};
  assign win     = (win_sum >= N_W) ? M'(win_sum - N_W) : M'(win_sum);

  assign gnt_c   = (i_en && found) ? (ONE << win) : '0;

  // Explicit compare-to-max keeps ptr inside 0..N-1 for non-power-of-two N.
  assign ptr_inc = (ptr == PMAX) ? '0 : ptr + 1'b1;
  assign win_inc = (win == PMAX) ? '0 : win + 1'b1;

  always_comb begin
    ptr_nxt = ptr_inc;
    if (TYPE == 1 && found) begin
      ptr_nxt = win_inc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      ptr <= '0;
    end else if (i_en) begin
      ptr <= ptr_nxt;
    end
  end

`ifdef RR_GNT_REG_EN
  logic [N-1:0] gnt_q;

  // gnt_c is already zero when i_en is low, so idle edges clear the grant.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_c;
    end
  end

  assign o_gnt = gnt_q;
`else
  assign o_gnt = gnt_c;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
module tb_round_robin_arbiter;

  localparam int N = 8;
`ifdef RR_GNT_REG_EN
  localparam int             LAT   = 1;
  localparam logic [N-1:0]   RST_G = 8'b00000000;
`else
  localparam int             LAT   = 0;
  localparam logic [N-1:0]   RST_G = 8'b00001000;
`endif

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         i_en;
  logic [N-1:0] i_req;
  logic [N-1:0] gnt1;
  logic [N-1:0] gnt0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int p1    = 0;
  int p0    = 0;

  typedef struct {
    logic [N-1:0] e1;
    logic [N-1:0] e0;
    int           due;
    string        tag;
  } exp_t;

  exp_t sb[$];

  round_robin_arbiter #(.N(N), .TYPE(1)) dut1 (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_en  (i_en),
    .i_req (i_req),
    .o_gnt (gnt1)
  );

  round_robin_arbiter #(.N(N), .TYPE(0)) dut0 (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_en  (i_en),
    .i_req (i_req),
    .o_gnt (gnt0)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  // Reference: walk ptr, ptr+1, ... mod N and grant the first requester.
  function automatic logic [N-1:0] model_gnt(input int p, input logic en,
                                             input logic [N-1:0] req, output int w);
    logic [N-1:0] g;
    g = '0;
    w = -1;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (p + k) % N;
        if (w < 0 && req[i]) w = i;
      end
    end
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  // Drive one cycle, queue the expected grants, advance the model pointers.
  task automatic step(input logic en, input logic [N-1:0] req, input string tag);
    int   w1, w0;
    exp_t e;
    i_en  = en;
    i_req = req;
    e.e1  = model_gnt(p1, en, req, w1);
    e.e0  = model_gnt(p0, en, req, w0);
    e.due = cyc + LAT;
    e.tag = tag;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (en) begin
      p0 = (p0 + 1) % N;
      p1 = (w1 >= 0) ? (w1 + 1) % N : (p1 + 1) % N;
    end
  endtask

  // Scoreboard: pop each expectation on the cycle its grant is visible.
  always @(negedge i_clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      total++;
      if (gnt1 !== e.e1) begin
        bad++;
        $display("FAIL gnt_type1 %s: got %b want %b", e.tag, gnt1, e.e1);
      end
      total++;
      if (gnt0 !== e.e0) begin
        bad++;
        $display("FAIL gnt_type0 %s: got %b want %b", e.tag, gnt0, e.e0);
      end
    end
  end

  task automatic do_reset();
    @(negedge i_clk);
    #1;
    i_rstn = 1'b1;
    i_en   = 1'b0;
    i_req  = '0;
    #2;
    i_rstn = 1'b0;
    p0 = 0;
    p1 = 0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b1;
    i_en   = 1'b1;
    i_req  = 8'b00101000;
    #1;
    total++;
    if (dut1.ptr !== 3'd0) begin
      bad++;
      $display("FAIL reset_ptr: got %0d want 0", dut1.ptr);
    end
    total++;
    if (gnt1 !== RST_G) begin
      bad++;
      $display("FAIL reset_gnt_en: got %b want %b", gnt1, RST_G);
    end
    i_en = 1'b0;
    #1;
    total++;
    if (gnt1 !== 8'b0) begin
      bad++;
      $display("FAIL reset_gnt_dis: got %b want 00000000", gnt1);
    end
    @(negedge i_clk);
    i_rstn = 1'b0;
    p0 = 0;
    p1 = 0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_first_and_rotation();
    step(1'b1, 8'b00101000, "first_arb");
    total++;
    if (dut1.ptr !== 3'd4) begin
      bad++;
      $display("FAIL first_ptr: got %0d want 4", dut1.ptr);
    end
    step(1'b1, 8'b00001010, "rotation");
    total++;
    if (dut1.ptr !== 3'd2) begin
      bad++;
      $display("FAIL rotation_ptr: got %0d want 2", dut1.ptr);
    end
  endtask

  task automatic test_conventional();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'b00000001, "conventional");
      total++;
      if (dut0.ptr !== 3'(k + 1)) begin
        bad++;
        $display("FAIL conv_ptr: got %0d want %0d", dut0.ptr, k + 1);
      end
    end
  endtask

  task automatic test_enable_gating();
    int s1, s0;
    s1 = p1;
    s0 = p0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'hFF, "en_low");
      total++;
      if (dut1.ptr !== 3'(s1) || dut0.ptr !== 3'(s0)) begin
        bad++;
        $display("FAIL en_hold_ptr: got %0d/%0d want %0d/%0d", dut1.ptr, dut0.ptr, s1, s0);
      end
    end
    step(1'b1, 8'hFF, "en_resume");
    total++;
    if (dut1.ptr !== 3'((s1 + 1) % N)) begin
      bad++;
      $display("FAIL en_resume_ptr: got %0d want %0d", dut1.ptr, (s1 + 1) % N);
    end
  endtask

  task automatic test_wrap_empty();
    do_reset();
    step(1'b1, 8'b01000000, "to_ptr7");
    total++;
    if (dut1.ptr !== 3'd7) begin
      bad++;
      $display("FAIL wrap_pre_ptr: got %0d want 7", dut1.ptr);
    end
    step(1'b1, 8'b10000000, "wrap_win7");
    total++;
    if (dut1.ptr !== 3'd0) begin
      bad++;
      $display("FAIL wrap_ptr: got %0d want 0", dut1.ptr);
    end
    step(1'b1, 8'b00000000, "empty_req");
    total++;
    if (dut1.ptr !== 3'd1) begin
      bad++;
      $display("FAIL empty_ptr: got %0d want 1", dut1.ptr);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'b00110000, "pre_rst_a");
    step(1'b1, 8'b00000100, "pre_rst_b");
    @(negedge i_clk);
    #1;
    i_rstn = 1'b1;
    #1;
    total++;
    if (dut1.ptr !== 3'd0 || dut0.ptr !== 3'd0) begin
      bad++;
      $display("FAIL async_rst_ptr: got %0d/%0d want 0/0", dut1.ptr, dut0.ptr);
    end
    i_en = 1'b0;
    #1;
    i_rstn = 1'b0;
    p0 = 0;
    p1 = 0;
    @(posedge i_clk);
    #1;
    step(1'b1, 8'hFF, "post_rst");
    total++;
    if (dut1.ptr !== 3'd1) begin
      bad++;
      $display("FAIL post_rst_ptr: got %0d want 1", dut1.ptr);
    end
  endtask

  task automatic test_soak();
    for (int k = 0; k < 100; k++) begin
      step(logic'($urandom_range(0, 3) != 0), 8'($urandom), "soak");
      total++;
      if (dut1.ptr !== 3'(p1) || dut0.ptr !== 3'(p0)) begin
        bad++;
        $display("FAIL soak_ptr: got %0d/%0d want %0d/%0d", dut1.ptr, dut0.ptr, p1, p0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 1'b1;
    i_en   = 1'b0;
    i_req  = '0;
    test_reset();
    test_first_and_rotation();
    test_conventional();
    test_enable_gating();
    test_wrap_empty();
    test_reset_mid();
    test_soak();
    i_en  = 1'b0;
    i_req = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
